// File: rtl/dfd_cla_pkg.sv
// dfd_cla_pkg: shared control type and sizing for the CLA counter bank.
package dfd_cla_pkg;
  localparam int unsigned CLA_NUMBER_OF_COUNTERS       = 4;
  localparam int unsigned CLA_COUNTER_WIDTH            = 31;
  localparam int unsigned NUMBER_OF_EVENTS_PER_COUNTER = 3;
  typedef struct packed {
    logic increment_pulse;
    logic clear_ctr;
    logic auto_increment;
    logic stop_auto_increment;
  } counter_controls;
endpackage

// File: rtl/dfd_cla_counter_slice.sv
// dfd_cla_counter_slice: one counter channel with target/saturate modes, exporting its wrap for chaining.
module dfd_cla_counter_slice
  import dfd_cla_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = CLA_COUNTER_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  counter_controls                         ctrl_i,
  input  logic [COUNTER_WIDTH-1:0]                target_i,
  input  logic                                    saturate_i,
  input  logic                                    clr_on_target_i,
  input  logic                                    chain_i,
  output logic [COUNTER_WIDTH-1:0]                value_o,
  output logic [NUMBER_OF_EVENTS_PER_COUNTER-1:0] events_o,
  output logic                                    ovf_sticky_o,
  output logic                                    wrap_o
);
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic auto_q, auto_d, ovf_q, ovf_d, tgt_q, tgt_d, sticky_q, sticky_d;
  logic inc, step, at_tgt, all_ones, hold;
  always_comb begin
    inc      = ctrl_i.increment_pulse | auto_q | chain_i;
    step     = inc & ~ctrl_i.clear_ctr;
    all_ones = &cnt_q;
    at_tgt   = clr_on_target_i & (cnt_q == target_i);
    wrap_o   = step & (at_tgt | (all_ones & ~saturate_i));
    hold     = step & saturate_i & all_ones & ~at_tgt;
    cnt_d    = (ctrl_i.clear_ctr | wrap_o) ? '0 : (step & ~hold) ? cnt_q + COUNTER_WIDTH'(1) : cnt_q;
    auto_d   = ctrl_i.stop_auto_increment ? 1'b0 : (ctrl_i.auto_increment | auto_q);
    ovf_d    = wrap_o;
    // Only the increment that first lands on the target fires; holding on it does not re-fire.
    tgt_d    = step & (cnt_d == target_i) & (cnt_q != target_i);
    sticky_d = ~ctrl_i.clear_ctr & (sticky_q | wrap_o | hold);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      auto_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tgt_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      auto_q   <= auto_d;
      ovf_q    <= ovf_d;
      tgt_q    <= tgt_d;
      sticky_q <= sticky_d;
    end
  end
  assign value_o      = cnt_q;
  assign events_o     = {auto_q, ovf_q, tgt_q};
  assign ovf_sticky_o = sticky_q;
endmodule

// File: rtl/dfd_cla_counter_bank.sv
// dfd_cla_counter_bank: bank of counter channels; wraps ripple combinationally into the next channel.
module dfd_cla_counter_bank
  import dfd_cla_pkg::*;
#(
  parameter int unsigned NUM_COUNTERS  = CLA_NUMBER_OF_COUNTERS,
  parameter int unsigned COUNTER_WIDTH = CLA_COUNTER_WIDTH
) (
  input  logic                                                 clk,
  input  logic                                                 reset_n,
  input  logic [NUM_COUNTERS*4-1:0]                            counter_actions,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0]                cfg_target,
  input  logic [NUM_COUNTERS-1:0]                              cfg_saturate,
  input  logic [NUM_COUNTERS-1:0]                              cfg_chain_en,
  input  logic [NUM_COUNTERS-1:0]                              cfg_clr_on_target,
  output logic [NUM_COUNTERS*COUNTER_WIDTH-1:0]                counter_value,
  output logic [NUM_COUNTERS*NUMBER_OF_EVENTS_PER_COUNTER-1:0] counter_events,
  output logic [NUM_COUNTERS-1:0]                              ovf_sticky
);
  logic [NUM_COUNTERS-1:0] wrap, chain;
  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_ch
    if (i == 0) begin : g_head
      assign chain[i] = 1'b0;
    end else begin : g_link
      assign chain[i] = cfg_chain_en[i] & wrap[i-1];
    end
    dfd_cla_counter_slice #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_slice (
      .clk             (clk),
      .reset_n         (reset_n),
      .ctrl_i          (counter_controls'(counter_actions[4*i +: 4])),
      .target_i        (cfg_target[COUNTER_WIDTH*i +: COUNTER_WIDTH]),
      .saturate_i      (cfg_saturate[i]),
      .clr_on_target_i (cfg_clr_on_target[i]),
      .chain_i         (chain[i]),
      .value_o         (counter_value[COUNTER_WIDTH*i +: COUNTER_WIDTH]),
      .events_o        (counter_events[NUMBER_OF_EVENTS_PER_COUNTER*i +: NUMBER_OF_EVENTS_PER_COUNTER]),
      .ovf_sticky_o    (ovf_sticky[i]),
      .wrap_o          (wrap[i])
    );
  end
endmodule

// File: tb/tb_dfd_cla_counter_bank.sv
// tb_dfd_cla_counter_bank: directed table, corner sequences and random traffic against an arithmetic model.
module tb_dfd_cla_counter_bank;
  localparam int NC   = 4;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [NC*4-1:0] acts;
  logic [NC*W-1:0] tgt;
  logic [NC-1:0] sat, chain_en, cot;
  logic [NC*W-1:0] counter_value;
  logic [NC*3-1:0] counter_events;
  logic [NC-1:0] ovf_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  int mv[NC];
  bit ma[NC], mo[NC], mt[NC], ms[NC];

  always #5 clk = ~clk;

  dfd_cla_counter_bank #(.NUM_COUNTERS(NC), .COUNTER_WIDTH(W)) dut (
    .clk               (clk),
    .reset_n           (rst_n),
    .counter_actions   (acts),
    .cfg_target        (tgt),
    .cfg_saturate      (sat),
    .cfg_chain_en      (chain_en),
    .cfg_clr_on_target (cot),
    .counter_value     (counter_value),
    .counter_events    (counter_events),
    .ovf_sticky        (ovf_sticky)
  );

  typedef struct {
    logic [3:0] act;
    logic [3:0] t;
    logic       s;
    logic       c;
    logic [3:0] exp_val;
    logic [2:0] exp_ev;
    logic       exp_sticky;
  } vec_t;

  function automatic vec_t mk(logic [3:0] a, logic [3:0] t, logic s, logic c,
                              logic [3:0] v, logic [2:0] e, logic st);
    vec_t r;
    r.act = a; r.t = t; r.s = s; r.c = c;
    r.exp_val = v; r.exp_ev = e; r.exp_sticky = st;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act_v, logic [63:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Reference: each channel stepped in index order so a wrap feeds the next channel in the same cycle.
  task automatic model_step();
    bit wp;
    wp = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        mv[i] = 0; ma[i] = 0; mo[i] = 0; mt[i] = 0; ms[i] = 0;
      end
      return;
    end
    for (int i = 0; i < NC; i++) begin
      int v, t, nv;
      bit inc, wr;
      logic [3:0] a;
      a = acts[4*i +: 4];
      v = mv[i];
      t = int'(tgt[W*i +: W]);
      nv = v;
      wr = 1'b0;
      inc = a[3] || ma[i] || (i > 0 && chain_en[i] && wp);
      mo[i] = 0;
      mt[i] = 0;
      if (a[2]) begin
        nv = 0;
        ms[i] = 0;
      end else if (inc) begin
        if (cot[i] && v == t) begin
          nv = 0; wr = 1;
        end else if (v == MAXV) begin
          if (sat[i]) ms[i] = 1;
          else begin nv = 0; wr = 1; end
        end else nv = v + 1;
        if (wr) begin mo[i] = 1; ms[i] = 1; end
        mt[i] = (nv == t) && (v != t);
      end
      if (a[0]) ma[i] = 0;
      else if (a[1]) ma[i] = 1;
      mv[i] = nv;
      wp = wr;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("val%0d", i), counter_value[W*i +: W], mv[i]);
      chk($sformatf("ev%0d", i), counter_events[3*i +: 3], {ma[i], mo[i], mt[i]});
      chk($sformatf("sticky%0d", i), ovf_sticky[i], ms[i]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_cfg();
    acts = '0; tgt = '1; sat = '0; chain_en = '0; cot = '0;
  endtask

  task automatic do_reset();
    idle_cfg();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    idle_cfg();
    tick();
    tick();
    chk("rst_val", counter_value, 0);
    chk("rst_ev", counter_events, 0);
    chk("rst_sticky", ovf_sticky, 0);
    rst_n = 1'b1;

    // act bits: {increment_pulse, clear_ctr, auto_increment, stop_auto_increment}
    tbl.push_back(mk(4'b1000, 4'd3, 0, 0, 4'd1, 3'b000, 0));
    tbl.push_back(mk(4'b1000, 4'd3, 0, 0, 4'd2, 3'b000, 0));
    tbl.push_back(mk(4'b1000, 4'd3, 0, 0, 4'd3, 3'b001, 0));
    tbl.push_back(mk(4'b0000, 4'd3, 0, 0, 4'd3, 3'b000, 0));
    tbl.push_back(mk(4'b0010, 4'd3, 0, 0, 4'd3, 3'b100, 0));
    tbl.push_back(mk(4'b0000, 4'd3, 0, 0, 4'd4, 3'b100, 0));
    tbl.push_back(mk(4'b1000, 4'd3, 0, 0, 4'd5, 3'b100, 0));
    tbl.push_back(mk(4'b0001, 4'd3, 0, 0, 4'd6, 3'b000, 0));
    tbl.push_back(mk(4'b0000, 4'd3, 0, 0, 4'd6, 3'b000, 0));
    tbl.push_back(mk(4'b0011, 4'd3, 0, 0, 4'd6, 3'b000, 0));
    tbl.push_back(mk(4'b0000, 4'd3, 0, 0, 4'd6, 3'b000, 0));
    tbl.push_back(mk(4'b1100, 4'd3, 0, 0, 4'd0, 3'b000, 0));
    tbl.push_back(mk(4'b1000, 4'd1, 0, 1, 4'd1, 3'b001, 0));
    tbl.push_back(mk(4'b1000, 4'd1, 0, 1, 4'd0, 3'b010, 1));
    tbl.push_back(mk(4'b0000, 4'd1, 0, 1, 4'd0, 3'b000, 1));
    tbl.push_back(mk(4'b0100, 4'd1, 0, 1, 4'd0, 3'b000, 0));
    foreach (tbl[k]) begin
      acts[3:0] = tbl[k].act;
      tgt[3:0]  = tbl[k].t;
      sat[0]    = tbl[k].s;
      cot[0]    = tbl[k].c;
      tick();
      chk($sformatf("tbl%0d_val", k), counter_value[3:0], tbl[k].exp_val);
      chk($sformatf("tbl%0d_ev", k), counter_events[2:0], tbl[k].exp_ev);
      chk($sformatf("tbl%0d_sticky", k), ovf_sticky[0], tbl[k].exp_sticky);
    end

    // Free-running wrap: 0..15,0,1 with one overflow pulse at the wrap
    do_reset();
    acts[3:0] = 4'b0010;
    tick();
    chk("wrap_start", counter_value[3:0], 0);
    acts = '0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("wrap_val", counter_value[3:0], k % 16);
      chk("wrap_ovf", counter_events[1], k == 16);
    end
    chk("wrap_sticky", ovf_sticky[0], 1);
    acts[3:0] = 4'b0001;
    tick();

    // Modulo-6 channel 0 chained into channel 1
    do_reset();
    tgt[3:0] = 4'd5; cot[0] = 1'b1; chain_en[1] = 1'b1;
    acts[3:0] = 4'b0010;
    tick();
    acts = '0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk("mod6_val", counter_value[3:0], k % 6);
      chk("mod6_tgt", counter_events[0], (k % 6) == 5);
      chk("mod6_ch1", counter_value[7:4], k / 6);
    end

    // Saturation holds at all-ones with no overflow pulse; clear drops sticky
    do_reset();
    sat[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      acts[3:0] = 4'b1000;
      tick();
      chk("sat_ovf", counter_events[1], 0);
    end
    chk("sat_val", counter_value[3:0], 15);
    chk("sat_sticky", ovf_sticky[0], 1);
    acts[3:0] = 4'b0100;
    tick();
    chk("sat_clr_val", counter_value[3:0], 0);
    chk("sat_clr_sticky", ovf_sticky[0], 0);

    // Pulse + auto + chain wrap on channel 1 in one cycle adds exactly one
    do_reset();
    chain_en[1] = 1'b1;
    acts[3:0] = 4'b1000;
    repeat (15) tick();
    acts = '0;
    acts[7:4] = 4'b0010;
    tick();
    acts[3:0] = 4'b1000;
    acts[7:4] = 4'b1000;
    tick();
    chk("multi_ch1", counter_value[7:4], 1);
    chk("multi_ch0", counter_value[3:0], 0);
    chk("multi_ovf0", counter_events[1], 1);
    acts = '0;
    acts[7:4] = 4'b1100;
    tick();
    chk("clrinc_ch1", counter_value[7:4], 0);
    acts[7:4] = 4'b0001;
    tick();

    // auto+stop together leaves auto off; reset at value 9 clears everything
    do_reset();
    acts[3:0] = 4'b0011;
    tick();
    chk("autostop", counter_events[2], 0);
    acts[3:0] = 4'b0010;
    tick();
    acts = '0;
    repeat (9) tick();
    chk("pre_rst_val", counter_value[3:0], 9);
    acts[3:0] = 4'b1000;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_val", counter_value, 0);
    chk("mid_rst_ev", counter_events, 0);
    chk("mid_rst_sticky", ovf_sticky, 0);
    rst_n = 1'b1;
    acts = '0;
    tick();
    chk("post_rst_val", counter_value, 0);
    chk("post_rst_ev", counter_events, 0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      if (k % 50 == 0) begin
        for (int i = 0; i < NC; i++) tgt[W*i +: W] = W'($urandom_range(0, MAXV));
        sat = NC'($urandom); chain_en = NC'($urandom); cot = NC'($urandom);
      end
      if ($urandom_range(0, 19) == 0) tgt[W*$urandom_range(0, NC-1) +: W] = W'($urandom_range(0, MAXV));
      for (int i = 0; i < NC; i++) begin
        acts[4*i+3] = $urandom_range(0, 1) == 1;
        acts[4*i+2] = $urandom_range(0, 24) == 0;
        acts[4*i+1] = $urandom_range(0, 7) == 0;
        acts[4*i+0] = $urandom_range(0, 9) == 0;
      end
      rst_n = $urandom_range(0, 99) != 0;
      tick();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dfd_cla_counter_bank.md
DFD_CLA_COUNTER_BANK -- requirements
Module: dfd_cla_counter_bank

Interface
REQ-001 Parameter NUM_COUNTERS, default 4 (dfd_cla_pkg::CLA_NUMBER_OF_COUNTERS), number of counter channels, range 1..16.
REQ-002 Parameter COUNTER_WIDTH, default 31 (dfd_cla_pkg::CLA_COUNTER_WIDTH), bits per counter, range 2..64.
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 counter_actions  in  NUM_COUNTERS*4  per-channel counter_controls {increment_pulse, clear_ctr, auto_increment, stop_auto_increment}, bits [4i+3:4i].
REQ-007 cfg_target  in  NUM_COUNTERS*COUNTER_WIDTH  per-channel compare value.
REQ-008 cfg_saturate  in  NUM_COUNTERS  1 = hold at all-ones instead of wrapping.
REQ-009 cfg_chain_en  in  NUM_COUNTERS  1 = channel i also increments on wrap of channel i-1; bit 0 ignored.
REQ-010 cfg_clr_on_target  in  NUM_COUNTERS  1 = count modulo target+1.
REQ-011 counter_value  out  NUM_COUNTERS*COUNTER_WIDTH  registered counter values.
REQ-012 counter_events  out  NUM_COUNTERS*3  per channel {auto_active, overflow_evt, target_evt}, bits [3i+2:3i].
REQ-013 ovf_sticky  out  NUM_COUNTERS  registered sticky overflow/saturation flag.

Function
REQ-014 inc_i SHALL be increment_pulse_i OR auto_active_i OR (cfg_chain_en_i AND wrap_{i-1}); multiple sources in one cycle SHALL add exactly 1.
REQ-015 clear_ctr_i SHALL win over inc_i: next counter 0, ovf_sticky_i 0, no events; auto_active_i unaffected by clear.
REQ-016 auto_active_i SHALL set on auto_increment, clear on stop_auto_increment; both same cycle -> cleared; takes effect for incrementing the following cycle.
REQ-017 Normal inc: counter_q+1 modulo 2^COUNTER_WIDTH; wrap_i (combinational) = inc_i AND counter_q == all-ones.
REQ-018 cfg_clr_on_target_i=1: inc with counter_q == cfg_target_i SHALL load 0 and assert wrap_i; otherwise as REQ-017.
REQ-019 cfg_saturate_i=1: inc at all-ones SHALL hold value, set ovf_sticky_i, wrap_i SHALL stay 0; clr_on_target takes precedence when target reached first.
REQ-020 target_evt_i SHALL be registered, high exactly one cycle: the cycle counter_value_i first equals cfg_target_i due to an increment; not asserted on reset or clear.
REQ-021 overflow_evt_i SHALL be registered, high one cycle after every wrap_i (counter then reads 0); ovf_sticky_i SHALL set on same edge.
REQ-022 Chain propagation SHALL be combinational and same-edge across all NUM_COUNTERS channels (ripple permitted, no added latency).
REQ-023 Config inputs SHALL take effect on the current cycle's evaluation; changing cfg_target mid-count SHALL NOT alter counter_value.
REQ-024 Latency: action at edge N -> counter_value/events updated after edge N.

Reset
REQ-025 reset_n=0 at a rising edge SHALL zero counter_value, counter_events, ovf_sticky, auto_active, overriding all actions that cycle.
REQ-026 Reset asserted mid-count or mid-chain SHALL leave no pending event after release.

Structure
REQ-027 counter_controls, CLA_NUMBER_OF_COUNTERS, CLA_COUNTER_WIDTH, NUMBER_OF_EVENTS_PER_COUNTER SHALL come from dfd_cla_pkg; no new local typedefs.
REQ-028 One sub-module dfd_cla_counter_slice (one channel, exports wrap) SHALL be instantiated NUM_COUNTERS times via generate; chain input tied 0 for channel 0.

Verification
REQ-029 W=4: auto_increment pulse, run 17 cycles -> values 0..15,0,1; overflow_evt one cycle at value 0; ovf_sticky=1.
REQ-030 target=5, clr_on_target=1, ch1 chain_en=1, ch0 auto -> ch0 cycles 0..5, target_evt at each 5, ch1 increments once per 6 cycles.
REQ-031 W=4 saturate=1, 20 increment_pulses -> holds 15, no overflow_evt, ovf_sticky=1; clear_ctr -> 0, sticky 0.
REQ-032 increment_pulse + auto_active + chain wrap same cycle -> +1 only; clear_ctr + increment_pulse -> 0.
REQ-033 auto_increment + stop_auto_increment same cycle -> auto_active 0; reset_n low mid-count at value 9 -> all outputs 0 next cycle.
